// File: rtl/motor_nn_pkg.sv
// Shared definitions for the motor MPC network datapath: default lane format,
// ReLU mode encoding and the packed-lane extract helper.
package motor_nn_pkg;

  localparam int unsigned LANE_W     = 21;
  localparam int unsigned LANE_I     = 7;
  localparam int unsigned LANE_MAX_W = 64;
  localparam int unsigned BUS_MAX_W  = 4096;

  typedef enum logic {
    RELU_MODE_PLAIN = 1'b0,
    RELU_MODE_CLIP  = 1'b1
  } relu_mode_e;

  // Returns lane idx of width w from a zero-extended packed bus.
  function automatic logic [LANE_MAX_W-1:0] lane_extract(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [LANE_MAX_W-1:0] mask;
    mask = (w >= LANE_MAX_W) ? '1 : ((LANE_MAX_W'(1) << w) - LANE_MAX_W'(1));
    return LANE_MAX_W'(bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/motor_relu_lane.sv
// Per-lane ReLU / clipped ReLU: input-side compares and S1-side result select.
// Leaky negative slope is built only when RELU_LEAKY_EN is defined.
module motor_relu_lane
  import motor_nn_pkg::*;
#(
  parameter int unsigned W = LANE_W
`ifdef RELU_LEAKY_EN
  ,
  parameter int unsigned LEAK_SHIFT = 3
`endif
) (
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] clip_in,
  input  logic         mode_in,
  output logic         pos_c,
  output logic         over_c,
  input  logic [W-1:0] x_q,
  input  logic [W-1:0] clip_q,
  input  logic         kill_q,
  input  logic         pos_q,
  input  logic         over_q,
  output logic [W-1:0] y_c
);

  // over_c is only raised for a strictly positive bound, so it implies pos_c.
  assign pos_c  = !x_in[W-1] && (x_in != '0);
  assign over_c = (mode_in == RELU_MODE_CLIP) && !clip_in[W-1] && (clip_in != '0) &&
                  ($signed(x_in) > $signed(clip_in));

  always_comb begin
    y_c = '0;
    if (pos_q && !kill_q) y_c = over_q ? clip_q : x_q;
`ifdef RELU_LEAKY_EN
    else if (x_q[W-1]) y_c = W'($signed(x_q) >>> LEAK_SHIFT);
`endif
  end

endmodule

// File: rtl/motor_relu_stream.sv
// Two-stage valid/ready ReLU / clipped ReLU over N_CH packed lanes with
// vector and clip counters. Optional leaky slope: define RELU_LEAKY_EN.
module motor_relu_stream
  import motor_nn_pkg::*;
#(
  parameter int unsigned W     = LANE_W,
  parameter int unsigned I     = LANE_I,
  parameter int unsigned N_CH  = 3,
  parameter int unsigned CNT_W = 16
`ifdef RELU_LEAKY_EN
  ,
  parameter int unsigned LEAK_SHIFT = 3
`endif
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic              cfg_mode,
  input  logic [W-1:0]      cfg_clip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH*W-1:0] out_data,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  clip_cnt
);

  localparam int unsigned DW    = N_CH * W;
  localparam int unsigned POP_W = 8;
  localparam int unsigned SUM_W = CNT_W + POP_W;

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_load_c;
  logic              s2_load_c;
  logic [DW-1:0]     s1_x;
  logic [W-1:0]      s1_clip;
  logic              s1_kill;
  logic [N_CH-1:0]   s1_pos;
  logic [N_CH-1:0]   s1_over;
  logic [N_CH-1:0]   pos_c;
  logic [N_CH-1:0]   over_c;
  logic [DW-1:0]     sel_c;
  logic              kill_c;
  logic [POP_W-1:0]  pop_c;
  logic [SUM_W-1:0]  clip_sum_c;
  logic              unused_fmt_c;

  // I only documents the fixed-point format; nothing is computed from it.
  assign unused_fmt_c = (I <= W);

  assign s2_load_c = !s2_valid || out_ready;
  assign s1_load_c = !s1_valid || s2_load_c;
  assign in_ready  = s1_load_c;
  assign out_valid = s2_valid;

  // Clip mode with a non-positive bound forces every positive lane to zero.
  assign kill_c = (cfg_mode == RELU_MODE_CLIP) && !($signed(cfg_clip) > $signed(W'(0)));

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    motor_relu_lane #(
      .W(W)
`ifdef RELU_LEAKY_EN
      ,
      .LEAK_SHIFT(LEAK_SHIFT)
`endif
    ) u_lane (
      .x_in   (W'(lane_extract(BUS_MAX_W'(in_data), k, W))),
      .clip_in(cfg_clip),
      .mode_in(cfg_mode),
      .pos_c  (pos_c[k]),
      .over_c (over_c[k]),
      .x_q    (s1_x[k*W +: W]),
      .clip_q (s1_clip),
      .kill_q (s1_kill),
      .pos_q  (s1_pos[k]),
      .over_q (s1_over[k]),
      .y_c    (sel_c[k*W +: W])
    );
  end

  assign pop_c      = POP_W'($countones(s1_over));
  assign clip_sum_c = SUM_W'(clip_cnt) + SUM_W'(pop_c);

  // Pipeline stages and counters; data registers load only with a valid beat.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_x     <= '0;
      s1_clip  <= '0;
      s1_kill  <= 1'b0;
      s1_pos   <= '0;
      s1_over  <= '0;
      out_data <= '0;
      vec_cnt  <= '0;
      clip_cnt <= '0;
    end else begin
      if (s1_load_c) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_x    <= in_data;
          s1_clip <= cfg_clip;
          s1_kill <= kill_c;
          s1_pos  <= pos_c;
          s1_over <= over_c;
        end
      end
      if (s2_load_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sel_c;
          clip_cnt <= (clip_sum_c > SUM_W'({CNT_W{1'b1}})) ? '1 : CNT_W'(clip_sum_c);
        end
      end
      if (s2_valid && out_ready) vec_cnt <= vec_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_motor_relu_stream.sv
// Self-checking bench for motor_relu_stream: directed beats, extremes, random
// backpressured stream against a lane-arithmetic reference, and mid-stream reset.
module tb_motor_relu_stream;

  localparam int unsigned W     = 21;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DW    = W * N_CH;

  localparam logic [W-1:0] P5_25 = 21'd86016;
  localparam logic [W-1:0] M1_0  = 21'h1FC000;
  localparam logic [W-1:0] P6_0  = 21'd98304;
  localparam logic [W-1:0] P7_5  = 21'd122880;
  localparam logic [W-1:0] P3_0  = 21'd49152;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             cfg_mode;
  logic [W-1:0]     cfg_clip;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] clip_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_clip   = 0;
  int            n_sent     = 0;
  int            n_out      = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          last_ov;
  logic [DW-1:0] last_od;
  logic          fired;
  logic [DW-1:0] pd;
  logic          pm;
  logic [W-1:0]  pc;
  logic          pend;
  int            acc;

  always #5 ap_clk = ~ap_clk;

  motor_relu_stream #(.W(W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cfg_mode (cfg_mode),
    .cfg_clip (cfg_clip),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .vec_cnt  (vec_cnt),
    .clip_cnt (clip_cnt)
  );

  function automatic logic [DW-1:0] pack3(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                          input logic [W-1:0] l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [W-1:0] ref_lane(input logic [W-1:0] x, input logic m,
                                            input logic [W-1:0] c);
    longint xv, cv, r;
    xv = longint'($signed(x));
    cv = longint'($signed(c));
    if (xv <= 0)      r = 0;
    else if (!m)      r = xv;
    else if (cv <= 0) r = 0;
    else              r = (xv < cv) ? xv : cv;
    return W'(r);
  endfunction

  function automatic logic [DW-1:0] ref_vec(input logic [DW-1:0] d, input logic m,
                                            input logic [W-1:0] c);
    logic [DW-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*W +: W] = ref_lane(d[k*W +: W], m, c);
    return v;
  endfunction

  function automatic int ref_clips(input logic [DW-1:0] d, input logic m, input logic [W-1:0] c);
    int n;
    longint xv, cv;
    n  = 0;
    cv = longint'($signed(c));
    for (int k = 0; k < N_CH; k++) begin
      xv = longint'($signed(d[k*W +: W]));
      if (m && cv > 0 && xv > cv) n++;
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int k = 0; k < N_CH; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*W +: W] = W'($urandom);
        1:       v[k*W +: W] = '0;
        default: v[k*W +: W] = W'($urandom_range(0, 262143)) - W'(131072);
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bench cycle: drive at negedge, sample after settle, score, advance.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic m,
                       input logic [W-1:0] c, input logic ordy);
    in_valid  = v;
    in_data   = d;
    cfg_mode  = m;
    cfg_clip  = c;
    out_ready = ordy;
    #1;
    last_ov = out_valid;
    last_od = out_data;
    fired   = v && in_ready;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", 64'(out_data), 64'(prev_data));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
      else chk("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
      n_out++;
    end
    if (fired) begin
      exp_q.push_back(ref_vec(d, m, c));
      exp_clip += ref_clips(d, m, c);
      n_sent++;
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic beat(input string tag, input logic [DW-1:0] d, input logic m,
                      input logic [W-1:0] c, input logic [DW-1:0] want);
    cycle(1'b1, d, m, c, 1'b1);
    chk({tag, "_accept"}, 64'(fired), 64'(1));
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk({tag, "_lat1"}, 64'(last_ov), 64'(0));
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk({tag, "_lat2"}, 64'(last_ov), 64'(1));
    chk({tag, "_data"}, 64'(last_od), 64'(want));
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_mode  = 1'b0;
    cfg_clip  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_vec_cnt", 64'(vec_cnt), 64'(0));
    chk("rst_clip_cnt", 64'(clip_cnt), 64'(0));
    ap_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge ap_clk);

    beat("relu", pack3(P5_25, M1_0, '0), 1'b0, '0, pack3(P5_25, '0, '0));
    chk("relu_vec_cnt", 64'(vec_cnt), 64'(1));
    chk("relu_clip_cnt", 64'(clip_cnt), 64'(0));

    beat("clip", pack3(P7_5, P6_0, P3_0), 1'b1, P6_0, pack3(P6_0, P6_0, P3_0));
    chk("clip_clip_cnt", 64'(clip_cnt), 64'(1));
    chk("clip_vec_cnt", 64'(vec_cnt), 64'(2));

    beat("ext_m0", pack3(21'h0FFFFF, 21'h100000, 21'h000001), 1'b0, '0,
         pack3(21'h0FFFFF, '0, 21'h000001));
    beat("ext_m1", pack3(21'h0FFFFF, 21'h100000, 21'h000001), 1'b1, 21'h1FFFFF, '0);
    chk("ext_clip_cnt", 64'(clip_cnt), 64'(1));

    // Back-to-back random stream with random downstream stalls.
    pend = 1'b0;
    acc  = 0;
    for (int cyc = 0; cyc < 2000 && acc < 100; cyc++) begin
      if (!pend) begin
        pd   = rand_vec();
        pm   = 1'($urandom_range(0, 1));
        pc   = W'($urandom_range(0, 200000)) - W'(30000);
        pend = 1'b1;
      end
      cycle(1'b1, pd, pm, pc, ($urandom_range(0, 2) != 0));
      if (fired) begin
        acc++;
        pend = 1'b0;
      end
    end
    chk("stream_accepted", 64'(acc), 64'(100));
    drain();
    chk("stream_out_count", 64'(n_out), 64'(n_sent));
    chk("stream_vec_cnt", 64'(vec_cnt), 64'(CNT_W'(n_sent)));
    chk("stream_clip_cnt", 64'(clip_cnt), 64'(CNT_W'(exp_clip)));

    // Fill both stages under backpressure, then reset for one cycle.
    cycle(1'b1, pack3(P7_5, P7_5, P7_5), 1'b1, P6_0, 1'b0);
    cycle(1'b1, pack3(P3_0, P3_0, P3_0), 1'b0, '0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(1));
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_vec_cnt", 64'(vec_cnt), 64'(0));
    chk("flush_clip_cnt", 64'(clip_cnt), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    stall_prev = 1'b0;
    n_sent     = 0;
    n_out      = 0;
    exp_clip   = 0;
    @(negedge ap_clk);
    chk("flush_no_output", 64'(out_valid), 64'(0));

    beat("post_rst", pack3(P5_25, M1_0, P3_0), 1'b0, '0, pack3(P5_25, '0, P3_0));
    chk("post_rst_vec_cnt", 64'(vec_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
